// File: rtl/data_memory_ctrl.sv
// Parametrised single-port data memory with valid/ready requests, a single-entry
// registered response slot, and a preload engine that runs after every reset.
module data_memory_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] HALF = IDX_W'(DEPTH / 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] init_word;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign in_range  = ($unsigned(32'(req_addr)) < $unsigned(32'(DEPTH)));
  assign idx       = req_addr[IDX_W-1:0];

  // Lower half counts up from zero, upper half counts down from zero (wrapping).
  assign init_word = (cnt < HALF) ? DATA_W'(cnt)
                                  : DATA_W'(HALF) - DATA_W'(cnt);

  // Single write port shared between the preload engine and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = init_word;
    if (!RST) begin
      if (state == INIT) begin
        mem_we = 1'b1;
      end else if (accept && req_write && in_range) begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          // A new accept overwrites the slot; otherwise a consumed response drains it.
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= (in_range && !req_write) ? mem[idx] : '0;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: a cycle-level reference model checked
// every cycle, directed scenarios with literal expectations, and random traffic.
module tb_data_memory_ctrl;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, init_busy;
  logic [7:0]  rsp_rdata;

  logic        rst2 = 1'b1;
  logic        req_valid2 = 1'b0;
  logic        req_write2 = 1'b0;
  logic [2:0]  req_addr2 = '0;
  logic [15:0] req_wdata2 = '0;
  logic        rsp_ready2 = 1'b1;
  logic        req_ready2, rsp_valid2, rsp_err2, init_busy2;
  logic [15:0] rsp_rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32)) dut (
    .clk(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_busy(init_busy)
  );

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut_small (
    .clk(clk), .RST(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
    .rsp_err(rsp_err2), .init_busy(init_busy2)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [7:0] pattern(input int i);
    return (i < DEPTH / 2) ? 8'(i) : 8'(DEPTH / 2 - i);
  endfunction

  // Reference model: time since reset, memory image and the one pending response.
  logic [7:0] m_mem [DEPTH];
  int         m_init = 0;
  bit         m_known = 1'b0;
  bit         m_rv = 1'b0;
  logic [7:0] m_rd = '0;
  bit         m_err = 1'b0;
  bit         m_rdy;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_init  = 0;
      m_rv    = 1'b0;
      m_rd    = '0;
      m_err   = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = pattern(i);
    end else if (m_known) begin
      if (m_init < DEPTH) begin
        m_init++;
      end else begin
        m_rdy = !m_rv || rsp_ready;
        if (req_valid && m_rdy) begin
          m_rv = 1'b1;
          if (int'(req_addr) >= DEPTH) begin
            m_err = 1'b1;
            m_rd  = '0;
          end else begin
            m_err = 1'b0;
            m_rd  = req_write ? 8'h00 : m_mem[req_addr];
            if (req_write) m_mem[req_addr] = req_wdata;
          end
        end else if (rsp_ready) begin
          m_rv = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check_output("init_busy", init_busy, m_init < DEPTH);
      check_output("req_ready", req_ready, (m_init == DEPTH) && (!m_rv || rsp_ready));
      check_output("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        check_output("rsp_rdata", rsp_rdata, m_rd);
        check_output("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] rd, output logic er);
    int guard = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) timeout_fail("accept");
    tick();
    req_valid = 1'b0;
    check_output("rsp_after_accept", rsp_valid, 1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_req_ready", req_ready, 0);
    check_output("reset_init_busy", init_busy, 1);
    check_output("reset_rsp_rdata", rsp_rdata, 0);
    check_output("reset_rsp_err", rsp_err, 0);
    rst = 1'b0;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (init_busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic        er;
    int          n;
    int          guard;
    logic [15:0] exp16 [8];

    tick();
    reset_dut();
    count_init(n);
    check_output("init_edges", n, 32);

    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 8'(i), 8'h00, rd, er);
      check_output("preload_word", rd, pattern(i));
      check_output("preload_err", er, 0);
      if (i == 15) check_output("preload_15", rd, 8'h0F);
      if (i == 16) check_output("preload_16", rd, 8'h00);
      if (i == 17) check_output("preload_17", rd, 8'hFF);
      if (i == 31) check_output("preload_31", rd, 8'hF1);
    end

    // Write then read the same word on consecutive edges.
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd7; req_wdata = 8'hA5;
    tick();
    req_write = 1'b0;
    check_output("b2b_wr_valid", rsp_valid, 1);
    check_output("b2b_wr_rdata", rsp_rdata, 8'h00);
    check_output("b2b_wr_err", rsp_err, 0);
    tick();
    req_valid = 1'b0;
    check_output("b2b_rd_valid", rsp_valid, 1);
    check_output("b2b_rd_rdata", rsp_rdata, 8'hA5);
    tick();
    check_output("b2b_drained", rsp_valid, 0);

    // Backpressure: response held while a second read waits.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
    tick();
    req_addr = 8'd4;
    for (int k = 0; k < 4; k++) begin
      check_output("bp_valid", rsp_valid, 1);
      check_output("bp_rdata", rsp_rdata, 8'h03);
      check_output("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check_output("bp_next_valid", rsp_valid, 1);
    check_output("bp_next_rdata", rsp_rdata, 8'h04);
    tick();

    apply_stimulus(1'b1, 8'd40, 8'h55, rd, er);
    check_output("oor_wr_err", er, 1);
    check_output("oor_wr_rdata", rd, 0);
    apply_stimulus(1'b0, 8'd40, 8'h00, rd, er);
    check_output("oor_rd_err", er, 1);
    check_output("oor_rd_rdata", rd, 0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 8'(i), 8'h00, rd, er);
      check_output("reread_word", rd, (i == 7) ? 8'hA5 : pattern(i));
    end

    // Random traffic including out-of-range addresses and response stalls.
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_write = ($urandom_range(0, 99) < 40);
      req_addr  = 8'($urandom_range(0, 39));
      req_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();

    // Reset with a pending response, then again in the middle of initialisation.
    apply_stimulus(1'b1, 8'd2, 8'h77, rd, er);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    check_output("pending_before_rst", rsp_valid, 1);
    reset_dut();
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_output("mid_init_busy", init_busy, 1);
    reset_dut();
    count_init(n);
    check_output("reinit_edges", n, 32);
    apply_stimulus(1'b0, 8'd2, 8'h00, rd, er);
    check_output("addr2_restored", rd, 8'h02);
    tick();

    // Narrow, wide instance: DEPTH=8, DATA_W=16.
    exp16 = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFD};
    rst2 = 1'b1;
    tick();
    check_output("small_reset_busy", init_busy2, 1);
    rst2 = 1'b0;
    n = 0;
    while (init_busy2 && n < 100) begin
      tick();
      n++;
    end
    check_output("small_init_edges", n, 8);
    for (int i = 0; i < 8; i++) begin
      req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 3'(i);
      guard = 0;
      while (!req_ready2 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) timeout_fail("small_accept");
      tick();
      req_valid2 = 1'b0;
      check_output("small_valid", rsp_valid2, 1);
      check_output("small_word", rsp_rdata2, exp16[i]);
      check_output("small_err", rsp_err2, 0);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
